// File: rtl/seg7_scan4.sv
// seg7_scan4: four-digit multiplexed common-anode 7-segment driver with leading-zero blanking
module seg7_scan4 #(
   parameter int REFRESH_DIV = 50_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits_in,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic [1:0]  dig_sel
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   digit_q, digit_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    cur;
   logic          wrap, z3, z2, z1, blank;
   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b0111111;
      endcase
   endfunction
   // Next-state: refresh timer, digit index, digit latch and the next registered frame
   always_comb begin
      wrap    = cnt_q == CW'(REFRESH_DIV - 1);
      cnt_d   = wrap ? '0 : cnt_q + CW'(1);
      idx_d   = wrap ? idx_q + 2'd1 : idx_q;
      digit_d = load ? digits_in : digit_q;
      cur     = digit_q[idx_q*4 +: 4];
      z3      = digit_q[15:12] == 4'd0;
      z2      = z3 && digit_q[11:8] == 4'd0;
      z1      = z2 && digit_q[7:4] == 4'd0;
      blank   = blank_lz && ((idx_q == 2'd3 && z3) || (idx_q == 2'd2 && z2) || (idx_q == 2'd1 && z1));
      an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d   = blank ? 7'b1111111 : dec(cur);
   end
   // State and output registers; reset darkens the display and restarts the scan at digit0
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         digit_q <= 16'h0000;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end
   assign an      = an_q;
   assign seg     = seg_q;
   assign dig_sel = idx_q;
endmodule

// File: tb/tb_seg7_scan4.sv
// tb_seg7_scan4: directed and randomized checks of seg7_scan4 against a time-based display model
module tb_seg7_scan4;
   localparam int DIV = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits_in = 16'h0000;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [1:0]  dig_sel;
   int          checks = 0;
   int          failures = 0;
   int          k = 0;
   logic [15:0] dreg = 16'h0000;
   logic [6:0]  seg_tab [16];
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic [1:0]  exp_sel;

   seg7_scan4 #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .an(an), .seg(seg), .dig_sel(dig_sel)
   );

   always #5 clk = ~clk;

   // One clock: apply inputs, predict the frame from the model state before the edge, then compare
   task automatic tick(input logic r, input logic ld, input logic [15:0] din, input logic blz);
      int pos;
      logic blanked;
      reset = r; load = ld; digits_in = din; blank_lz = blz;
      @(posedge clk);
      if (r) begin
         exp_an = 4'b1111; exp_seg = 7'b1111111; k = 0; dreg = 16'h0000;
      end else begin
         pos = (k / DIV) % 4;
         blanked = blz && pos != 0 && (dreg >> (4 * pos)) == 16'h0000;
         exp_an  = blanked ? 4'b1111 : 4'(~(1 << pos));
         exp_seg = blanked ? 7'b1111111 : seg_tab[(dreg >> (4 * pos)) & 16'hF];
         k++;
         if (ld) dreg = din;
      end
      exp_sel = 2'((k / DIV) % 4);
      #1;
      checks++;
      assert (an === exp_an) else begin
         failures++; $error("FAIL an k=%0d got=%b exp=%b", k, an, exp_an);
      end
      checks++;
      assert (seg === exp_seg) else begin
         failures++; $error("FAIL seg k=%0d got=%b exp=%b", k, seg, exp_seg);
      end
      checks++;
      assert (dig_sel === exp_sel) else begin
         failures++; $error("FAIL dig_sel k=%0d got=%0d exp=%0d", k, dig_sel, exp_sel);
      end
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      tick(1, 0, 16'h0000, 0);
      tick(1, 1, 16'hFFFF, 0);
      tick(0, 1, 16'h1234, 0);
      for (int i = 0; i < 20; i++) tick(0, 0, 16'h0000, 0);
      tick(0, 1, 16'h0050, 1);
      for (int i = 0; i < 17; i++) tick(0, 0, 16'h0000, 1);
      for (int i = 0; i < 17; i++) tick(0, 0, 16'h0000, 0);
      tick(0, 1, 16'h0000, 1);
      for (int i = 0; i < 17; i++) tick(0, 0, 16'h0000, 1);
      tick(0, 1, 16'h00A0, 0);
      for (int i = 0; i < 17; i++) tick(0, 0, 16'h0000, 0);
      for (int i = 0; i < 16 && (k % 16) != 15; i++) tick(0, 0, 16'h0000, 0);
      tick(0, 1, 16'h9999, 0);
      for (int i = 0; i < 4; i++) tick(0, 0, 16'h0000, 0);
      for (int i = 0; i < 16 && ((k / DIV) % 4) != 2; i++) tick(0, 0, 16'h0000, 0);
      tick(0, 0, 16'h0000, 0);
      tick(1, 0, 16'h0000, 0);
      for (int i = 0; i < 8; i++) tick(0, 0, 16'h0000, 0);
      for (int i = 0; i < 400; i++)
         tick($urandom_range(59) == 0, $urandom_range(4) == 0, 16'($urandom), 1'($urandom_range(3) != 0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
